// File: rtl/mem_access_sequencer_pkg.sv
// Shared definitions for the data-memory access sequencer: size encodings,
// controller states and the alignment rule applied when a request is captured.
package mem_seq_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    DONE,
    ERR
  } state_t;

  // The reserved size encoding is treated as misaligned so one check covers both
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = addr_lo[0];
      SZ_WORD: is_misaligned = |addr_lo;
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Bundle of the datapath request handshake and the data-memory port.
// The slave modport is the sequencer; the master modport is datapath plus memory.
interface mem_access_sequencer_if #(parameter int ADDR_W = 32);

  logic              req;
  logic              mem_read;
  logic              mem_write;
  logic [1:0]        size;
  logic              signed_ld;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wr_data;
  logic              stall;
  logic              done;
  logic              err;
  logic [31:0]       rd_data;
  logic [ADDR_W-3:0] dm_addr;
  logic              dm_re;
  logic              dm_we;
  logic [31:0]       dm_wdata;
  logic [31:0]       dm_rdata;

  modport slave (
    input  req, mem_read, mem_write, size, signed_ld, addr, wr_data, dm_rdata,
    output stall, done, err, rd_data, dm_addr, dm_re, dm_we, dm_wdata
  );

  modport master (
    output req, mem_read, mem_write, size, signed_ld, addr, wr_data, dm_rdata,
    input  stall, done, err, rd_data, dm_addr, dm_re, dm_we, dm_wdata
  );

endinterface

// File: rtl/mem_access_sequencer_byte_lane_unit.sv
// Little-endian lane logic: extract/extend a sub-word from a memory word and
// merge store data into a memory word. Purely combinational.
module byte_lane_unit
  import mem_seq_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [4:0]  w_bit_ofs;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_bit_ofs = {i_lane, 3'b000};
  assign w_byte    = i_word[w_bit_ofs +: 8];
  assign w_half    = i_lane[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_load   = i_word;
    o_merged = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        o_load   = {{24{i_signed & w_byte[7]}}, w_byte};
        o_merged = i_word;
        o_merged[w_bit_ofs +: 8] = i_wdata[7:0];
      end
      SZ_HALF: begin
        o_load   = {{16{i_signed & w_half[15]}}, w_half};
        o_merged = i_lane[1] ? {i_wdata[15:0], i_word[15:0]}
                             : {i_word[31:16], i_wdata[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Multi-cycle sequencer turning one load/store request into data-memory cycles,
// with read-modify-write for sub-word stores and extended sub-word loads.
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 32
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  mem_access_sequencer_if.slave bus
);

  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_signed;
  logic              r_load;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic [1:0]        r_wcnt;
  logic              w_illegal;
  logic              w_last_wait;
  logic [31:0]       w_load;
  logic [31:0]       w_merged;

  assign w_illegal   = (bus.mem_read == bus.mem_write) || is_misaligned(bus.size, bus.addr[1:0]);
  assign w_last_wait = (r_state == WAIT) && (r_wcnt == 2'd0);
  assign bus.rd_data = r_rdata;

  byte_lane_unit u_lane (
    .i_word   (bus.dm_rdata),
    .i_lane   (r_addr[1:0]),
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Memory data is consumed on the last WAIT cycle: loads keep the extended
  // value, sub-word stores overwrite the captured store data with the merged word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr   <= '0;
      r_size   <= '0;
      r_signed <= 1'b0;
      r_load   <= 1'b0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_wcnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.req) begin
          r_addr   <= bus.addr;
          r_size   <= bus.size;
          r_signed <= bus.signed_ld;
          r_load   <= bus.mem_read;
          r_wdata  <= bus.wr_data;
        end
        READ: r_wcnt <= LAT_M1;
        WAIT: begin
          if (r_wcnt != 2'd0) r_wcnt  <= r_wcnt - 2'd1;
          else if (r_load)    r_rdata <= w_load;
          else                r_wdata <= w_merged;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next       = r_state;
    bus.stall    = 1'b0;
    bus.done     = 1'b0;
    bus.err      = 1'b0;
    bus.dm_re    = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_wdata = '0;
    bus.dm_addr  = '0;
    if (r_state != IDLE) bus.dm_addr = r_addr[ADDR_W-1:2];
    case (r_state)
      IDLE: begin
        bus.stall = bus.req & i_rst_n;
        if (bus.req) begin
          if (w_illegal)                                  w_next = ERR;
          else if (bus.mem_write && bus.size == SZ_WORD)  w_next = WRITE;
          else                                            w_next = READ;
        end
      end
      READ: begin
        bus.stall = 1'b1;
        bus.dm_re = 1'b1;
        w_next    = WAIT;
      end
      WAIT: begin
        bus.stall = 1'b1;
        if (w_last_wait) w_next = r_load ? DONE : WRITE;
      end
      WRITE: begin
        bus.stall    = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_wdata = r_wdata;
        w_next       = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        w_next   = IDLE;
      end
      ERR: begin
        bus.done = 1'b1;
        bus.err  = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Randomised self-checking bench: two sequencers (read latency 1 and 3) share a
// simple data memory and are compared against an arithmetic reference model.
module tb_mem_access_sequencer;
  import mem_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;
  logic        req, memRead, memWrite, signedLd;
  logic [1:0]  size;
  logic [31:0] addr, wrData;
  logic [31:0] dmRData;

  mem_access_sequencer_if #(.ADDR_W(32)) bus1 ();
  mem_access_sequencer_if #(.ADDR_W(32)) bus3 ();

  mem_access_sequencer #(.RD_LAT(1), .ADDR_W(32)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));
  mem_access_sequencer #(.RD_LAT(3), .ADDR_W(32)) dut3 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus3));

  assign bus1.req       = req & ~sel;
  assign bus3.req       = req & sel;
  assign bus1.mem_read  = memRead;   assign bus3.mem_read  = memRead;
  assign bus1.mem_write = memWrite;  assign bus3.mem_write = memWrite;
  assign bus1.size      = size;      assign bus3.size      = size;
  assign bus1.signed_ld = signedLd;  assign bus3.signed_ld = signedLd;
  assign bus1.addr      = addr;      assign bus3.addr      = addr;
  assign bus1.wr_data   = wrData;    assign bus3.wr_data   = wrData;
  assign bus1.dm_rdata  = dmRData;   assign bus3.dm_rdata  = dmRData;

  logic        obsStall, obsDone, obsErr, obsDmRe, obsDmWe;
  logic [31:0] obsRdData, obsDmWData;
  logic [29:0] obsDmAddr;
  assign obsStall   = sel ? bus3.stall    : bus1.stall;
  assign obsDone    = sel ? bus3.done     : bus1.done;
  assign obsErr     = sel ? bus3.err      : bus1.err;
  assign obsDmRe    = sel ? bus3.dm_re    : bus1.dm_re;
  assign obsDmWe    = sel ? bus3.dm_we    : bus1.dm_we;
  assign obsRdData  = sel ? bus3.rd_data  : bus1.rd_data;
  assign obsDmWData = sel ? bus3.dm_wdata : bus1.dm_wdata;
  assign obsDmAddr  = sel ? bus3.dm_addr  : bus1.dm_addr;

  // Memory model: writes land at the clock edge, read data appears RD_LAT cycles after DmRe
  logic [31:0] simMem [0:255];
  logic [31:0] rdPipe [0:3];
  logic        preEn;
  logic [7:0]  preIdx;
  logic [31:0] preVal;

  always @(posedge clk) begin
    if (preEn)        simMem[preIdx] <= preVal;
    else if (obsDmWe) simMem[obsDmAddr[7:0]] <= obsDmWData;
    rdPipe[0] <= obsDmRe ? simMem[obsDmAddr[7:0]] : 32'hDEAD_0BAD;
    for (int i = 1; i < 4; i++) rdPipe[i] <= rdPipe[i-1];
  end
  assign dmRData = sel ? rdPipe[2] : rdPipe[0];

  logic [31:0] refMem [0:255];
  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic bit isIllegal(bit rd, bit wr, int sz, int a);
    return (rd == wr) || (sz == 3) || (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] refLoad(logic [31:0] w, int a, int sz, bit sgn);
    longint v;
    int sh;
    sh = (a % 4) * 8;
    if (sz == 0) begin
      v = longint'((w >> sh) & 32'hFF);
      if (sgn && v >= 128) v = v - 256;
    end else if (sz == 1) begin
      v = longint'((w >> sh) & 32'hFFFF);
      if (sgn && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(w);
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] refStore(logic [31:0] old, int a, int sz, logic [31:0] d);
    logic [31:0] mask;
    int sh;
    sh = (a % 4) * 8;
    if (sz == 2) return d;
    mask = (sz == 0) ? (32'hFF << sh) : (32'hFFFF << sh);
    return (old & ~mask) | ((d << sh) & mask);
  endfunction

  task automatic preload(input int idx, input logic [31:0] v);
    @(negedge clk);
    preEn  = 1'b1;
    preIdx = idx[7:0];
    preVal = v;
    @(negedge clk);
    preEn = 1'b0;
    refMem[idx] = v;
  endtask

  task automatic applyStimulus(input bit rd, input bit wr, input logic [1:0] sz, input bit sgn,
                               input int a, input logic [31:0] wd);
    int lat, idx, expCycles, n, reCnt, weCnt;
    bit bad, stallGap, clash, addrBad;
    logic [31:0] seenW, expWord, expLoad;
    lat = sel ? 3 : 1;
    idx = a / 4;
    bad = isIllegal(rd, wr, int'(sz), a);
    if (bad)                  expCycles = 1;
    else if (wr && sz == 2'd2) expCycles = 2;
    else if (rd)              expCycles = 2 + lat;
    else                      expCycles = 3 + lat;
    n = 0; reCnt = 0; weCnt = 0; clash = 0; addrBad = 0; seenW = '0;
    @(negedge clk);
    req = 1'b1; memRead = rd; memWrite = wr; size = sz; signedLd = sgn;
    addr = a; wrData = wd;
    #1;
    stallGap = !obsStall;
    while (1) begin
      @(negedge clk);
      n++;
      if (obsDmRe && obsDmWe) clash = 1;
      if (obsDmRe) reCnt++;
      if (obsDmWe) begin
        weCnt++;
        seenW = obsDmWData;
        if (obsDmAddr !== 30'(idx)) addrBad = 1;
      end
      if (obsDone || n >= 20) break;
      if (!obsStall) stallGap = 1;
    end
    checkOutput("done_cycle", 32'(n), 32'(expCycles));
    checkOutput("err", 32'(obsErr), 32'(bad));
    checkOutput("stall_done", 32'(obsStall), 32'd0);
    checkOutput("stall_hold", 32'(stallGap), 32'd0);
    checkOutput("re_we_clash", 32'(clash), 32'd0);
    checkOutput("dm_re_cnt", 32'(reCnt), (bad || (wr && sz == 2'd2)) ? 32'd0 : 32'd1);
    checkOutput("dm_we_cnt", 32'(weCnt), (!bad && wr) ? 32'd1 : 32'd0);
    if (!bad && wr) begin
      expWord = refStore(refMem[idx], a, int'(sz), wd);
      refMem[idx] = expWord;
      checkOutput("dm_wdata", seenW, expWord);
      checkOutput("dm_addr", 32'(addrBad), 32'd0);
    end
    if (!bad && rd) begin
      expLoad = refLoad(refMem[idx], a, int'(sz), sgn);
      checkOutput("rd_data", obsRdData, expLoad);
    end
    req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a, r;
    bit rd, wr;
    logic [1:0] sz;
    rst_n = 1'b0; sel = 1'b0; req = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    size = 2'd0; signedLd = 1'b0; addr = '0; wrData = '0; preEn = 1'b0;
    preIdx = '0; preVal = '0;
    repeat (3) @(negedge clk);
    req = 1'b1;
    #1;
    checkOutput("rst_stall", 32'(obsStall), 32'd0);
    checkOutput("rst_done", 32'(obsDone | obsErr), 32'd0);
    checkOutput("rst_rd_data", obsRdData, 32'd0);
    checkOutput("rst_dm_addr", 32'(obsDmAddr), 32'd0);
    checkOutput("rst_dm_strobe", 32'({obsDmRe, obsDmWe}), 32'd0);
    checkOutput("rst_dm_wdata", obsDmWData, 32'd0);
    checkOutput("rst_dut3", 32'({bus3.stall, bus3.done, bus3.dm_re, bus3.dm_we}) | bus3.rd_data, 32'd0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 256; i++) preload(i, $urandom);

    preload(32'h40, 32'h1122_3344);
    applyStimulus(1, 0, SZ_BYTE, 1, 32'h103, 32'h0);
    preload(32'h40, 32'h0080_0000);
    applyStimulus(1, 0, SZ_BYTE, 1, 32'h102, 32'h0);
    applyStimulus(1, 0, SZ_BYTE, 0, 32'h102, 32'h0);
    applyStimulus(0, 1, SZ_WORD, 0, 32'h100, 32'hDEAD_BEEF);
    applyStimulus(1, 0, SZ_WORD, 0, 32'h100, 32'h0);
    preload(32'h80, 32'hAABB_CCDD);
    applyStimulus(0, 1, SZ_HALF, 0, 32'h202, 32'h0000_1234);
    applyStimulus(1, 0, SZ_WORD, 0, 32'h102, 32'h0);
    applyStimulus(0, 1, SZ_HALF, 0, 32'h201, 32'h0000_5678);

    // Abort a byte read-modify-write while it waits for read data
    preload(32'h50, 32'hCAFE_F00D);
    @(negedge clk);
    req = 1'b1; memRead = 1'b0; memWrite = 1'b1; size = SZ_BYTE; addr = 32'h141; wrData = 32'h77;
    @(negedge clk);
    checkOutput("sb_read", 32'(obsDmRe), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_outs", 32'({obsStall, obsDone, obsErr, obsDmRe, obsDmWe}), 32'd0);
    checkOutput("abort_dm_addr", 32'(obsDmAddr), 32'd0);
    checkOutput("abort_rd_data", obsRdData, 32'd0);
    req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 0, SZ_WORD, 0, 32'h140, 32'h0);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      begin rd = 1; wr = 1; end
      else if (r == 1) begin rd = 0; wr = 0; end
      else             begin rd = 1'($urandom_range(0, 1)); wr = !rd; end
      sz = ($urandom_range(0, 8) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = $urandom_range(0, 1023);
      if ($urandom_range(0, 3) != 0) a = a & ~((sz == 2'd1) ? 1 : (sz == 2'd2) ? 3 : 0);
      applyStimulus(rd, wr, sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    sel = 1'b1;
    preload(0, 32'h0000_FFFE);
    applyStimulus(1, 0, SZ_HALF, 1, 32'h0, 32'h0);
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      begin rd = 1; wr = 1; end
      else if (r == 1) begin rd = 0; wr = 0; end
      else             begin rd = 1'($urandom_range(0, 1)); wr = !rd; end
      sz = ($urandom_range(0, 8) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = $urandom_range(0, 1023);
      if ($urandom_range(0, 3) != 0) a = a & ~((sz == 2'd1) ? 1 : (sz == 2'd2) ? 3 : 0);
      applyStimulus(rd, wr, sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    @(negedge clk);
    checkOutput("idle_dm_addr", 32'(obsDmAddr), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
